// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: decode->execute bus; master drives D-side controls and hazard signals, slave returns E-side copies.
// Ports: StallE/FlushE/ValidD + *D controls/data (master->slave), *E copies + ValidE (+BubbleCntE with ID_EX_BUBBLE_CNT_EN).
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int RADDR_W = 5
`ifdef ID_EX_BUBBLE_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic StallE, FlushE, ValidD;
  logic RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0] ALUControlD;
  logic [DATA_W-1:0] RD1D, RD2D, SignImmD;
  logic [RADDR_W-1:0] RsD, RtD, RdD;
  logic ValidE;
  logic RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0] ALUControlE;
  logic [DATA_W-1:0] RD1E, RD2E, SignImmE;
  logic [RADDR_W-1:0] RsE, RtE, RdE;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] BubbleCntE;
`endif
  modport master(
`ifdef ID_EX_BUBBLE_CNT_EN
    input BubbleCntE,
`endif
    output StallE, FlushE, ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
    output ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD,
    input ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
    input ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE
  );
  modport slave(
`ifdef ID_EX_BUBBLE_CNT_EN
    output BubbleCntE,
`endif
    input StallE, FlushE, ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
    input ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD,
    output ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
    output ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register with stall hold, flush/invalid bubbles and optional bubble counter (ID_EX_BUBBLE_CNT_EN).
// Ports: clk, reset (sync, active-high), bus (id_ex_pipe_reg_if.slave).
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int RADDR_W = 5
`ifdef ID_EX_BUBBLE_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic clk,
  input logic reset,
  id_ex_pipe_reg_if.slave bus
);
  localparam int W = 9 + 3 * DATA_W + 3 * RADDR_W;
  logic [W-1:0] r_e;
  logic [W-1:0] w_d;
  logic w_bubble;
  assign w_d = {bus.ValidD, bus.RegWriteD, bus.MemtoRegD, bus.MemWriteD, bus.ALUSrcD, bus.RegDstD,
                bus.ALUControlD, bus.RD1D, bus.RD2D, bus.RsD, bus.RtD, bus.RdD, bus.SignImmD};
  assign {bus.ValidE, bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE, bus.RegDstE,
          bus.ALUControlE, bus.RD1E, bus.RD2E, bus.RsE, bus.RtE, bus.RdE, bus.SignImmE} = r_e;
  // an invalid decode slot loads as a bubble so stray controls never become write enables
  assign w_bubble = bus.FlushE | (~bus.StallE & ~bus.ValidD);
  always_ff @(posedge clk) begin
    if (reset) r_e <= '0;
    else if (w_bubble) r_e <= '0;
    else if (!bus.StallE) r_e <= w_d;
  end
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  assign bus.BubbleCntE = r_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (w_bubble && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: vector table, hand sequences and randomized model check of id_ex_pipe_reg.
module tb_id_ex_pipe_reg;
`ifdef ID_EX_BUBBLE_CNT_EN
  localparam int CW = 2;
  localparam int MAXC = (1 << CW) - 1;
`endif
  typedef struct packed {
    logic v, rw, m2r, mw, as, rdst;
    logic [2:0] alu;
    logic [31:0] rd1, rd2;
    logic [4:0] rs, rt, rd;
    logic [31:0] imm;
  } e_t;
  typedef struct {
    logic rst, stall, flush;
    e_t d;
    e_t exp;
  } vec_t;
  logic clk = 0;
  logic reset;
  int compared = 0;
  int mismatched = 0;
`ifdef ID_EX_BUBBLE_CNT_EN
  id_ex_pipe_reg_if #(.DATA_W(32), .RADDR_W(5), .CNT_W(CW)) bus ();
  id_ex_pipe_reg #(.DATA_W(32), .RADDR_W(5), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  id_ex_pipe_reg_if #(.DATA_W(32), .RADDR_W(5)) bus ();
  id_ex_pipe_reg #(.DATA_W(32), .RADDR_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;
  function automatic e_t rnd();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[119:0];
  endfunction
  function automatic e_t get_e();
    e_t e;
    e = '{bus.ValidE, bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE, bus.RegDstE,
          bus.ALUControlE, bus.RD1E, bus.RD2E, bus.RsE, bus.RtE, bus.RdE, bus.SignImmE};
    return e;
  endfunction
  task automatic drive(input logic r, input logic s, input logic f, input e_t d);
    reset = r;
    bus.StallE = s;
    bus.FlushE = f;
    bus.ValidD = d.v;
    bus.RegWriteD = d.rw;
    bus.MemtoRegD = d.m2r;
    bus.MemWriteD = d.mw;
    bus.ALUSrcD = d.as;
    bus.RegDstD = d.rdst;
    bus.ALUControlD = d.alu;
    bus.RD1D = d.rd1;
    bus.RD2D = d.rd2;
    bus.RsD = d.rs;
    bus.RtD = d.rt;
    bus.RdD = d.rd;
    bus.SignImmD = d.imm;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  vec_t tv[10];
  e_t z, a, b, c, dv, d, m;
  logic rs, st, fl;
`ifdef ID_EX_BUBBLE_CNT_EN
  int mc;
  int cseq[8];
  logic sseq[8];
`endif
  initial begin
    z = '0;
    a = '0;
    a.v = 1;
    a.rw = 1;
    a.alu = 3'b001;
    a.rd1 = 32'h0000_0005;
    a.rt = 5'd9;
    b = rnd();
    b.v = 1;
    b.mw = 1;
    c = rnd();
    c.v = 0;
    c.rw = 1'bx;
    c.mw = 1'bx;
    dv = rnd();
    dv.v = 1;
    tv[0] = '{1'b1, 1'b0, 1'b0, rnd(), z};
    tv[1] = '{1'b1, 1'b0, 1'b0, rnd(), z};
    tv[2] = '{1'b0, 1'b0, 1'b0, a, a};
    tv[3] = '{1'b0, 1'b1, 1'b0, rnd(), a};
    tv[4] = '{1'b0, 1'b1, 1'b0, rnd(), a};
    tv[5] = '{1'b0, 1'b1, 1'b0, rnd(), a};
    tv[6] = '{1'b0, 1'b1, 1'b1, b, z};
    tv[7] = '{1'b0, 1'b0, 1'b0, c, z};
    tv[8] = '{1'b0, 1'b0, 1'b0, dv, dv};
    tv[9] = '{1'b1, 1'b1, 1'b1, rnd(), z};
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].rst, tv[i].stall, tv[i].flush, tv[i].d);
      step();
      check($sformatf("vec%0d", i), {8'h0, get_e()}, {8'h0, tv[i].exp});
    end
    drive(0, 0, 0, a);
    step();
    check("seq_load", {8'h0, get_e()}, {8'h0, a});
    drive(1, 1, 0, dv);
    step();
    check("seq_rst_in_stall", {8'h0, get_e()}, {8'h0, z});
    drive(0, 1, 0, dv);
    step();
    check("seq_stall_after_rst", {8'h0, get_e()}, {8'h0, z});
    drive(0, 0, 0, dv);
    step();
    check("seq_reload", {8'h0, get_e()}, {8'h0, dv});
`ifdef ID_EX_BUBBLE_CNT_EN
    drive(1, 0, 0, dv);
    step();
    check("cnt_reset", {112'h0, bus.BubbleCntE}, 128'h0);
    sseq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    cseq = '{1, 1, 1, 2, 2, 3, 3, 3};
    for (int i = 0; i < 8; i++) begin
      drive(0, sseq[i], ~sseq[i], dv);
      step();
      check($sformatf("cnt_seq%0d", i), {112'h0, bus.BubbleCntE}, 128'(cseq[i]));
    end
    mc = 0;
`endif
    m = z;
    for (int i = 0; i < 400; i++) begin
      rs = (i == 0) || ($urandom_range(31) == 0);
      fl = $urandom_range(5) == 0;
      st = $urandom_range(3) == 0;
      d = rnd();
      d.v = $urandom_range(3) != 0;
      drive(rs, st, fl, d);
      step();
      if (rs) m = z;
      else if (fl || (!st && !d.v)) m = z;
      else if (!st) m = d;
`ifdef ID_EX_BUBBLE_CNT_EN
      if (rs) mc = 0;
      else if (fl || (!st && !d.v)) mc = (mc + 1 > MAXC) ? MAXC : mc + 1;
      check($sformatf("rnd_cnt%0d", i), {112'h0, bus.BubbleCntE}, 128'(mc));
`endif
      check($sformatf("rnd%0d", i), {8'h0, get_e()}, {8'h0, m});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
